gpio_write_arbiter: RTL

- Shares one AXI4-Lite write master port into the AXI GPIO between NUM_REQ local requesters, for example the traffic generator and a software shim.
- Each requester presents an address/data pair. The block arbitrates round-robin, runs one complete AW/W/B transaction, and returns a per-requester completion pulse with error status.
- Sits between the requesters and the GPIO slave, in the 300 MHz single-ended domain after the differential clock buffer.

---
 rtl/gpio_arb_pkg.sv | 21 ++
 rtl/gpio_write_arbiter_rr_arbiter.sv | 38 +++
 rtl/gpio_write_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO write arbiter.
//   state_e      : arbiter FSM state encoding
//   BRESP_*      : AXI write response codes
package gpio_arb_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ADDR_DATA = 2'd1;
    localparam logic [1:0] ST_RESP      = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ADDR_DATA = ST_ADDR_DATA,
        RESP      = ST_RESP
    } state_e;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/gpio_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : per-requester request bits
//   last_grant : index of the previously served requester
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : binary index of the granted requester
// Search starts at last_grant+1 and wraps, so the last winner has lowest priority.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int            cand;
    logic [IW-1:0] cidx;

    // Walk the offsets from farthest to nearest; the nearest requesting
    // position overwrites any earlier hit and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        cidx      = '0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % N;
            cidx = IW'(cand);
            if (req[cidx]) begin
                grant       = '0;
                grant[cidx] = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

endmodule

// File: rtl/gpio_write_arbiter.sv
// Shares one AXI4-Lite write master into the GPIO slave between NUM_REQ
// local requesters. One complete AW/W/B transaction at a time, round-robin
// service, per-requester completion pulse with error flag.
//   clk, reset            : system clock, synchronous active-high reset
//   req_valid/addr/data   : flattened per-requester write requests
//   req_ready             : one-hot accept (only in IDLE)
//   done_valid, done_err  : completion pulse and BRESP error flag
//   m_aw*, m_w*, m_b*     : AXI4-Lite write channels toward the GPIO slave
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | arbitrate, accept one request, latch addr/data
// ADDR_DATA | AW and W channels in flight, completing independently
// RESP      | waiting for the B response, then pulse done
module gpio_write_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            done_valid,
    output logic                          done_err,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [DATA_WIDTH/8-1:0]       m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                state;
    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         idx;
    logic                  aw_done;
    logic                  w_done;

    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         grant_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_ok;
    logic                  w_ok;
    logic                  resp_err;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = (state == IDLE) && (|grant);
    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    // A channel counts as finished if it completed earlier or is completing now.
    assign aw_ok     = aw_done | aw_hs;
    assign w_ok      = w_done | w_hs;
    // SLVERR and DECERR both flag an error; OKAY/EXOKAY do not.
    assign resp_err  = (m_bresp == BRESP_SLVERR) || (m_bresp == BRESP_DECERR);
    assign m_wstrb   = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            idx        <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            m_awaddr   <= '0;
            m_wdata    <= '0;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            done_valid <= '0;
            done_err   <= 1'b0;
        end else begin
            done_valid <= '0;
            done_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_awaddr   <= sel_addr;
                        m_wdata    <= sel_data;
                        idx        <= grant_idx;
                        last_grant <= grant_idx;
                        m_awvalid  <= 1'b1;
                        m_wvalid   <= 1'b1;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        state      <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (aw_hs) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        m_bready <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (m_bvalid) begin
                        m_bready        <= 1'b0;
                        done_valid[idx] <= 1'b1;
                        done_err        <= resp_err;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
